// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/interrupt sequencer between the MEM stage and the CSR file.
// Accepts one event per trap from the MEM stage (or a pending external
// interrupt). It then emits a one-cycle CSR pulse with a registered payload
// (COMMIT), followed by a one-cycle PC redirect (REDIRECT). The pipeline is
// flushed in both of those cycles.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   ext_irq             asynchronous level interrupt request
//   mie                 global machine interrupt enable (mstatus[3])
//   mtvec, mepc         trap vector / exception return address
//   valid_mem, stall    MEM-stage valid, pipeline stall
//   *_mem flags         MEM-stage event flags
//   pc_mem .. addr_mem  MEM-stage payload captured on acceptance
//   interrupt .. mret   one-cycle CSR event pulses
//   epc_cur .. mem_addr_cur  payload held until the next acceptance
//   mem_kill            combinational kill of the accepted MEM instruction
//   flush               flush IF..MEM during COMMIT and REDIRECT
//   redirect_valid/pc   PC redirect strobe and target
//   trap_count          saturating count of taken traps (mret excluded)
module trap_ctrl #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ext_irq,
   input  logic        mie,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   input  logic        valid_mem,
   input  logic        stall,
   input  logic        ill_mem,
   input  logic        lfault_mem,
   input  logic        sfault_mem,
   input  logic        ecall_mem,
   input  logic        mret_mem,
   input  logic [31:0] pc_mem,
   input  logic [31:0] pc_next_mem,
   input  logic [31:0] inst_mem,
   input  logic [31:0] addr_mem,
   output logic        interrupt,
   output logic        illegal_inst,
   output logic        l_access_fault,
   output logic        s_access_fault,
   output logic        ecall_m,
   output logic        mret,
   output logic [31:0] epc_cur,
   output logic [31:0] epc_next,
   output logic [31:0] inst_cur,
   output logic [31:0] mem_addr_cur,
   output logic        mem_kill,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [15:0] trap_count
);

   typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;
   typedef enum logic [2:0] {EV_IRQ, EV_ILL, EV_LFAULT, EV_SFAULT, EV_ECALL, EV_MRET} event_t;

   state_t                 state;
   event_t                 kind;
   event_t                 sel;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   irq_s;
   logic                   irq_d;
   logic                   irq_rise;
   logic                   irq_pending;
   logic                   irq_take;
   logic                   any_event;
   logic                   accept;

   assign irq_s     = sync_q[SYNC_STAGES-1];
   assign irq_rise  = irq_s & ~irq_d;
   assign irq_take  = irq_pending & mie;
   assign any_event = irq_take | ill_mem | lfault_mem | sfault_mem | ecall_mem | mret_mem;
   // rst is folded in so the combinational kill is also 0 while in reset.
   assign accept    = rst & (state == IDLE) & valid_mem & ~stall & any_event;
   // An accepted interrupt lets the MEM instruction retire; everything else kills it.
   assign mem_kill  = accept & (sel != EV_IRQ);

   always_comb begin
      sel = EV_MRET;
      if (irq_take)        sel = EV_IRQ;
      else if (ill_mem)    sel = EV_ILL;
      else if (lfault_mem) sel = EV_LFAULT;
      else if (sfault_mem) sel = EV_SFAULT;
      else if (ecall_mem)  sel = EV_ECALL;
   end

   // Synchroniser, edge detector and pending flag. A new edge beats the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q      <= '0;
         irq_d       <= 1'b0;
         irq_pending <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], ext_irq};
         irq_d       <= irq_s;
         irq_pending <= irq_rise | (irq_pending & ~(accept & (sel == EV_IRQ)));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         kind           <= EV_IRQ;
         interrupt      <= 1'b0;
         illegal_inst   <= 1'b0;
         l_access_fault <= 1'b0;
         s_access_fault <= 1'b0;
         ecall_m        <= 1'b0;
         mret           <= 1'b0;
         epc_cur        <= '0;
         epc_next       <= '0;
         inst_cur       <= '0;
         mem_addr_cur   <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         trap_count     <= '0;
      end else begin
         interrupt      <= 1'b0;
         illegal_inst   <= 1'b0;
         l_access_fault <= 1'b0;
         s_access_fault <= 1'b0;
         ecall_m        <= 1'b0;
         mret           <= 1'b0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  epc_cur        <= pc_mem;
                  epc_next       <= pc_next_mem;
                  inst_cur       <= inst_mem;
                  mem_addr_cur   <= addr_mem;
                  kind           <= sel;
                  interrupt      <= (sel == EV_IRQ);
                  illegal_inst   <= (sel == EV_ILL);
                  l_access_fault <= (sel == EV_LFAULT);
                  s_access_fault <= (sel == EV_SFAULT);
                  ecall_m        <= (sel == EV_ECALL);
                  mret           <= (sel == EV_MRET);
                  flush          <= 1'b1;
                  state          <= COMMIT;
               end
            end
            COMMIT: begin
               flush          <= 1'b1;
               redirect_valid <= 1'b1;
               redirect_pc    <= (kind == EV_MRET) ? mepc : mtvec;
               if (kind != EV_MRET && trap_count != 16'hFFFF)
                  trap_count <= trap_count + 16'd1;
               state          <= REDIRECT;
            end
            REDIRECT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of flops in the ext_irq synchroniser (legal values 2..3).
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ext_irq  in  1  asynchronous external interrupt request, level.
- mie  in  1  mstatus[3] from the CSR file.
- mtvec, mepc  in  32  current CSR values.
- valid_mem, stall  in  1  MEM-stage instruction valid; pipeline stall.
- ill_mem, lfault_mem, sfault_mem, ecall_mem, mret_mem  in  1  MEM-stage event flags.
- pc_mem, pc_next_mem, inst_mem, addr_mem  in  32  MEM-stage PC, next PC, instruction word, memory address.
- interrupt, illegal_inst, l_access_fault, s_access_fault, ecall_m, mret  out  1  one-cycle pulses to the CSR file.
- epc_cur, epc_next, inst_cur, mem_addr_cur  out  32  registered payload to the CSR file.
- mem_kill  out  1  combinational; suppresses the MEM instruction's side effects in the acceptance cycle.
- flush  out  1  flushes IF..MEM.
- redirect_valid  out  1  one-cycle PC redirect strobe.
- redirect_pc  out  32  redirect target.
- trap_count  out  16  count of taken traps, saturating.

Function
REQ-003 SHALL synchronise ext_irq through SYNC_STAGES flops before any use.
REQ-004 SHALL set irq_pending on a rising edge of the synchronised ext_irq, and SHALL clear it only in the cycle an interrupt is accepted; if the clear and a new edge occur in the same cycle, set SHALL win.
REQ-005 SHALL implement FSM states IDLE, COMMIT and REDIRECT.
REQ-006 In IDLE, SHALL accept an event when valid_mem=1, stall=0, and at least one of the following holds: (irq_pending and mie), ill_mem, lfault_mem, sfault_mem, ecall_mem, mret_mem.
REQ-007 SHALL select a single accepted event by fixed priority: interrupt > illegal > load fault > store fault > ecall > mret.
REQ-008 On acceptance, SHALL register pc_mem, pc_next_mem, inst_mem and addr_mem into epc_cur, epc_next, inst_cur and mem_addr_cur, latch the event kind, and move to COMMIT.
REQ-009 SHALL assert mem_kill in the acceptance cycle for every event except an interrupt; for an interrupt the MEM instruction completes and epc_next is the return address.
REQ-010 In COMMIT (exactly 1 cycle), SHALL drive exactly one event pulse high, assert flush, and move to REDIRECT.
REQ-011 In REDIRECT (exactly 1 cycle), SHALL assert flush and redirect_valid, set redirect_pc = mepc for mret and mtvec otherwise, and return to IDLE.
REQ-012 Latency SHALL be: CSR pulse 1 cycle after acceptance; redirect 2 cycles after acceptance.
REQ-013 The payload registers SHALL hold their values until the next acceptance.
REQ-014 In COMMIT and REDIRECT, SHALL ignore all MEM-stage event flags (those instructions are being flushed), while irq_pending SHALL still update.
REQ-015 SHALL not accept any event while stall=1, and irq_pending SHALL persist through the stall.
REQ-016 SHALL accept an interrupt with mie=0 only once mie later becomes 1 while irq_pending is still set.
REQ-017 SHALL increment trap_count by 1 at each COMMIT for trap events (mret excluded) and SHALL saturate it at 16'hFFFF.
REQ-018 Outside COMMIT, all event pulses SHALL be 0; outside COMMIT and REDIRECT, flush SHALL be 0; outside REDIRECT, redirect_valid SHALL be 0 and redirect_pc SHALL be 0.

Reset
REQ-019 While rst=0, SHALL place the FSM in IDLE and force all outputs, irq_pending, the synchroniser flops, the payload registers and trap_count to 0.
REQ-020 On reset assertion in COMMIT or REDIRECT, SHALL abort with no pulse or redirect after rst deasserts.
REQ-021 SHALL accept events on the first rising edge after rst deasserts.

Verification
REQ-022 Illegal instruction: ill_mem=1, pc_mem=0x100, inst_mem=0xFFFFFFFF, mtvec=0x78 -> mem_kill=1 in cycle 0; illegal_inst pulse with epc_cur=0x100 and inst_cur=0xFFFFFFFF in cycle 1; redirect_valid=1 and redirect_pc=0x78 in cycle 2; trap_count=1.
REQ-023 Interrupt beats ecall: ext_irq held high ≥3 cycles, mie=1, then ecall_mem=1 with pc_next_mem=0x204 -> interrupt pulse only, mem_kill=0, epc_next=0x204; irq_pending cleared.
REQ-024 Masked interrupt: ext_irq edge with mie=0 for 10 cycles -> no pulse; then mie=1 with valid_mem=1 -> interrupt accepted on that cycle.
REQ-025 Mret: mret_mem=1, mepc=0x300 -> mret pulse in cycle 1; redirect_pc=0x300 in cycle 2; trap_count unchanged.
REQ-026 Stall and shadow: lfault_mem=1 with stall=1 for 3 cycles -> no acceptance; then stall=0 -> accept with mem_addr_cur = addr_mem; sfault_mem=1 raised during COMMIT -> ignored.
REQ-027 Reset and saturation: rst=0 asserted in COMMIT -> all outputs 0 and no redirect afterwards; with trap_count preset to 0xFFFF via 65535 traps, one further trap -> trap_count remains 0xFFFF.
